plot_arbiter: RTL and testbench

Round-robin arbiter and raster sequencer sharing the single VGA adapter plot port among several box drawers (sprite draw, sprite erase, score/overlay). Each requester posts a rectangle (origin, size, colour). The block grants one requester at a time and scans that rectangle one pixel per clock onto `x`/`y`/`colour`/`plot`. It sits between the game FSMs and `vga_adapter` at 160x120, 3-bit colour.

---
 rtl/plot_arbiter_pkg.sv | 34 +++
 rtl/plot_arbiter_rr_arbiter.sv | 49 ++++
 rtl/plot_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_plot_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_arbiter_pkg.sv
// Shared constants, sequencer state encoding and the latched rectangle record
// used by the plot arbiter and its round-robin select.
package plot_arbiter_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int DIM_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [DIM_W-1:0]    w_m1;
    logic [DIM_W-1:0]    h_m1;
    logic [COLOUR_W-1:0] colour;
  } rect_t;

  function automatic logic is_last_pixel(input logic [DIM_W-1:0] cx,
                                         input logic [DIM_W-1:0] cy,
                                         input rect_t            r);
    return (cx == r.w_m1) && (cy == r.h_m1);
  endfunction

endpackage

// File: rtl/plot_arbiter_rr_arbiter.sv
// Round-robin select: combinational one-hot winner searched from last-served+1,
// with the last-served pointer registered and advanced on the update strobe.
module rr_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_update,
  output logic [NUM_REQ-1:0] o_winner
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_cand;
  logic [PTR_W-1:0]   w_win_idx;
  logic [NUM_REQ-1:0] w_winner;
  logic               w_found;

  // Candidates visited in order ptr+1, ptr+2, ... wrapping; first requester wins.
  always_comb begin
    w_winner  = '0;
    w_win_idx = '0;
    w_cand    = '0;
    w_found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        w_winner[w_cand] = 1'b1;
        w_win_idx        = w_cand;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= PTR_W'(NUM_REQ - 1);
    end else if (i_update && w_found) begin
      r_ptr <= w_win_idx;
    end
  end

  assign o_winner = w_winner;

endmodule

// File: rtl/plot_arbiter.sv
// Shares one VGA plot port among NUM_REQ rectangle drawers, scanning the granted box one pixel/clock.
// Optional PLOT_ARBITER_CLIP_EN suppresses plot for pixels beyond the 160x120 screen.
module plot_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [X_W*NUM_REQ-1:0]      i_req_x,
  input  logic [Y_W*NUM_REQ-1:0]      i_req_y,
  input  logic [DIM_W*NUM_REQ-1:0]    i_req_w_m1,
  input  logic [DIM_W*NUM_REQ-1:0]    i_req_h_m1,
  input  logic [COLOUR_W*NUM_REQ-1:0] i_req_colour,
  output logic [NUM_REQ-1:0]          o_grant,
  output logic [NUM_REQ-1:0]          o_done,
  output logic                        o_busy,
  output logic [X_W-1:0]              o_x,
  output logic [Y_W-1:0]              o_y,
  output logic [COLOUR_W-1:0]         o_colour,
  output logic                        o_plot
);

  state_t               r_state;
  state_t               w_state_nxt;
  rect_t                r_rect;
  rect_t                w_sel_rect;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic [NUM_REQ-1:0]   w_winner;
  logic                 r_busy;
  logic                 r_plot;
  logic [X_W-1:0]       r_x;
  logic [Y_W-1:0]       r_y;
  logic [COLOUR_W-1:0]  r_colour;
  logic [DIM_W-1:0]     r_cx;
  logic [DIM_W-1:0]     r_cy;
  logic [DIM_W-1:0]     w_cx_nxt;
  logic [DIM_W-1:0]     w_cy_nxt;
  logic                 w_last;
  logic                 w_pix_vld;
  logic                 w_arb_upd;
  logic                 w_on_screen;
  logic [X_W-1:0]       w_org_x;
  logic [Y_W-1:0]       w_org_y;
  logic [COLOUR_W-1:0]  w_org_colour;
  logic [X_W-1:0]       w_x_nxt;
  logic [Y_W-1:0]       w_y_nxt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_req    (i_req),
    .i_update (w_arb_upd),
    .o_winner (w_winner)
  );

  // Parameters of the granted requester, captured into r_rect during LOAD.
  always_comb begin
    w_sel_rect = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_sel_rect.x      = i_req_x[X_W*i +: X_W];
        w_sel_rect.y      = i_req_y[Y_W*i +: Y_W];
        w_sel_rect.w_m1   = i_req_w_m1[DIM_W*i +: DIM_W];
        w_sel_rect.h_m1   = i_req_h_m1[DIM_W*i +: DIM_W];
        w_sel_rect.colour = i_req_colour[COLOUR_W*i +: COLOUR_W];
      end
    end
  end

  assign w_last = is_last_pixel(r_cx, r_cy, r_rect);

  always_comb begin
    w_state_nxt = r_state;
    w_cx_nxt    = r_cx;
    w_cy_nxt    = r_cy;
    w_pix_vld   = 1'b0;
    w_arb_upd   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          w_state_nxt = ST_LOAD;
          w_arb_upd   = 1'b1;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_DRAW;
        w_cx_nxt    = '0;
        w_cy_nxt    = '0;
        w_pix_vld   = 1'b1;
      end
      ST_DRAW: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_pix_vld = 1'b1;
          if (r_cx == r_rect.w_m1) begin
            w_cx_nxt = '0;
            w_cy_nxt = r_cy + 1'b1;
          end else begin
            w_cx_nxt = r_cx + 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered one pixel ahead, so LOAD uses the not-yet-latched origin.
  assign w_org_x      = (r_state == ST_LOAD) ? w_sel_rect.x      : r_rect.x;
  assign w_org_y      = (r_state == ST_LOAD) ? w_sel_rect.y      : r_rect.y;
  assign w_org_colour = (r_state == ST_LOAD) ? w_sel_rect.colour : r_rect.colour;

`ifdef PLOT_ARBITER_CLIP_EN
  logic [X_W:0] w_x_full;
  logic [Y_W:0] w_y_full;

  assign w_x_full    = (X_W+1)'(w_org_x) + (X_W+1)'(w_cx_nxt);
  assign w_y_full    = (Y_W+1)'(w_org_y) + (Y_W+1)'(w_cy_nxt);
  assign w_x_nxt     = w_x_full[X_W-1:0];
  assign w_y_nxt     = w_y_full[Y_W-1:0];
  assign w_on_screen = (w_x_full < (X_W+1)'(SCREEN_W)) && (w_y_full < (Y_W+1)'(SCREEN_H));
`else
  assign w_x_nxt     = w_org_x + X_W'(w_cx_nxt);
  assign w_y_nxt     = w_org_y + Y_W'(w_cy_nxt);
  assign w_on_screen = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rect   <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_plot   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
    end else begin
      if (r_state == ST_LOAD) begin
        r_rect <= w_sel_rect;
      end
      r_cx   <= w_cx_nxt;
      r_cy   <= w_cy_nxt;
      r_plot <= w_pix_vld && w_on_screen;
      if (w_pix_vld) begin
        r_x      <= w_x_nxt;
        r_y      <= w_y_nxt;
        r_colour <= w_org_colour;
      end
      if (w_arb_upd) begin
        r_grant <= w_winner;
      end else if (r_state == ST_DONE) begin
        r_grant <= '0;
      end
      r_done <= (r_state == ST_DRAW && w_last) ? r_grant : '0;
      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_grant  = r_grant;
  assign o_done   = r_done;
  assign o_busy   = r_busy;
  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_colour = r_colour;
  assign o_plot   = r_plot;

endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: expected pixels queued per rectangle, popped on every plot.
module tb_plot_arbiter;

  localparam int N = 2;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_x;
  logic [7*N-1:0] req_y;
  logic [4*N-1:0] req_w_m1;
  logic [4*N-1:0] req_h_m1;
  logic [3*N-1:0] req_colour;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic           plot;

  int   checks = 0;
  int   errors = 0;
  pix_t exp_q[$];
  pix_t mon_got;
  pix_t mon_want;

  plot_arbiter #(.NUM_REQ(N)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (req),
    .i_req_x      (req_x),
    .i_req_y      (req_y),
    .i_req_w_m1   (req_w_m1),
    .i_req_h_m1   (req_h_m1),
    .i_req_colour (req_colour),
    .o_grant      (grant),
    .o_done       (done),
    .o_busy       (busy),
    .o_x          (x),
    .o_y          (y),
    .o_colour     (colour),
    .o_plot       (plot)
  );

  always #5 clk = ~clk;

  // Every plotted pixel must match the head of the expected queue.
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      mon_got = {x, y, colour};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected got (%0d,%0d) c%0d, required no plot", x, y, colour);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          errors++;
          $display("FAIL pixel got (%0d,%0d) c%0d, required (%0d,%0d) c%0d",
                   mon_got.x, mon_got.y, mon_got.c, mon_want.x, mon_want.y, mon_want.c);
        end
      end
    end
  end

  task automatic set_slot(input int i, input int ox, input int oy,
                          input int wm1, input int hm1, input int col);
    req_x[8*i +: 8]      = 8'(ox);
    req_y[7*i +: 7]      = 7'(oy);
    req_w_m1[4*i +: 4]   = 4'(wm1);
    req_h_m1[4*i +: 4]   = 4'(hm1);
    req_colour[3*i +: 3] = 3'(col);
  endtask

  task automatic push_rect(input int ox, input int oy, input int wm1, input int hm1, input int col);
    int px;
    int py;
    pix_t p;
    for (int cy = 0; cy <= hm1; cy++) begin
      for (int cx = 0; cx <= wm1; cx++) begin
        px = ox + cx;
        py = oy + cy;
`ifdef PLOT_ARBITER_CLIP_EN
        if (px >= 160 || py >= 120) continue;
`endif
        p.x = px[7:0];
        p.y = py[6:0];
        p.c = col[2:0];
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    checks++; if (plot !== 1'b0)   begin errors++; $display("FAIL rst_plot got %b required 0", plot); end
    checks++; if (x !== 8'd0)      begin errors++; $display("FAIL rst_x got %0d required 0", x); end
    checks++; if (y !== 7'd0)      begin errors++; $display("FAIL rst_y got %0d required 0", y); end
    checks++; if (colour !== 3'd0) begin errors++; $display("FAIL rst_colour got %0d required 0", colour); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b required 00", grant); end
    checks++; if (done !== 2'b00)  begin errors++; $display("FAIL rst_done got %b required 00", done); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, plot, grant} !== 4'b0000) begin
      errors++; $display("FAIL idle_no_req got busy/plot/grant %b required 0000", {busy, plot, grant});
    end
  endtask

  task automatic test_single();
    int k_first = -1;
    int k_last  = -1;
    int k_done  = -1;
    int n       = 0;
    logic [N-1:0] g1 = '0;
    logic b1 = 1'b0;
    do_reset();
    set_slot(0, 10, 20, 3, 1, 7);
    push_rect(10, 20, 3, 1, 7);
    req = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin g1 = grant; b1 = busy; end
      if (plot === 1'b1) begin
        if (k_first < 0) k_first = k;
        k_last = k;
        n++;
      end
      if (done !== 2'b00) begin
        k_done = k;
        req = '0;
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL single_done_idx got %b required 01", done); end
        break;
      end
    end
    checks++; if (g1 !== 2'b01)  begin errors++; $display("FAIL single_load_grant got %b required 01", g1); end
    checks++; if (b1 !== 1'b1)   begin errors++; $display("FAIL single_load_busy got %b required 1", b1); end
    checks++; if (k_first != 2)  begin errors++; $display("FAIL single_first_plot got %0d required 2", k_first); end
    checks++; if (k_last != 9)   begin errors++; $display("FAIL single_last_plot got %0d required 9", k_last); end
    checks++; if (k_done != 10)  begin errors++; $display("FAIL single_done_cycle got %0d required 10", k_done); end
    checks++; if (n != 8)        begin errors++; $display("FAIL single_plot_count got %0d required 8", n); end
    @(negedge clk);
    checks++;
    if ({busy, grant} !== 3'b000) begin
      errors++; $display("FAIL single_back_idle got busy/grant %b required 000", {busy, grant});
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_contention();
    int nd = 0;
    int last_plot = -1;
    logic [N-1:0] exp_d;
    do_reset();
    set_slot(0, 30, 40, 1, 1, 2);
    set_slot(1, 50, 60, 1, 1, 5);
    push_rect(30, 40, 1, 1, 2);
    push_rect(50, 60, 1, 1, 5);
    push_rect(30, 40, 1, 1, 2);
    push_rect(50, 60, 1, 1, 5);
    req = 2'b11;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (plot === 1'b1) begin
        if (last_plot >= 0 && k - last_plot > 1) begin
          checks++;
          if (k - last_plot != 4) begin
            errors++; $display("FAIL contention_gap got %0d idle cycles required 3", k - last_plot - 1);
          end
        end
        last_plot = k;
      end
      if (done !== 2'b00) begin
        exp_d = (nd % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (done !== exp_d || grant !== exp_d) begin
          errors++; $display("FAIL contention_turn%0d got done %b grant %b required %b", nd, done, grant, exp_d);
        end
        nd++;
        if (nd == 4) begin req = '0; break; end
      end
    end
    checks++; if (nd != 4) begin errors++; $display("FAIL contention_done_count got %0d required 4", nd); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL contention_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_midservice();
    int n = 0;
    int k_done = -1;
    bit dropped = 1'b0;
    do_reset();
    set_slot(0, 0, 0, 0, 0, 0);
    set_slot(1, 70, 30, 2, 1, 6);
    push_rect(70, 30, 2, 1, 6);
    req = 2'b10;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (plot === 1'b1) begin
        n++;
        if (!dropped) begin
          req[1] = 1'b0;
          set_slot(1, 100, 5, 0, 0, 1);
          dropped = 1'b1;
        end
        if (n == 3) begin
          checks++; if (grant !== 2'b10) begin errors++; $display("FAIL mid_grant_held got %b required 10", grant); end
        end
      end
      if (done !== 2'b00) begin
        k_done = k;
        checks++; if (done !== 2'b10) begin errors++; $display("FAIL mid_done_idx got %b required 10", done); end
        break;
      end
    end
    checks++; if (n != 6)      begin errors++; $display("FAIL mid_plot_count got %0d required 6", n); end
    checks++; if (k_done != 8) begin errors++; $display("FAIL mid_done_cycle got %0d required 8", k_done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int k_done = -1;
    do_reset();
    set_slot(0, 5, 5, 3, 3, 1);
    push_rect(5, 5, 3, 3, 1);
    req = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (plot === 1'b1) n++;
      if (n == 5) begin reset = 1'b1; req = '0; break; end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL rmid_reach_pixel5 got %0d required 5", n); end
    @(negedge clk);
    exp_q.delete();
    checks++;
    if ({plot, x, y, colour, grant, done, busy} !== 24'd0) begin
      errors++; $display("FAIL rmid_outputs got plot %b x %0d y %0d c %0d grant %b done %b busy %b required all 0",
                         plot, x, y, colour, grant, done, busy);
    end
    @(negedge clk);
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL rmid_no_done got %b required 00", done); end
    reset = 1'b0;
    set_slot(0, 1, 2, 0, 0, 3);
    set_slot(1, 3, 4, 0, 0, 4);
    push_rect(1, 2, 0, 0, 3);
    req = 2'b11;
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_first_winner got %b required 01", grant); end
    req = '0;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (done !== 2'b00) begin k_done = k; break; end
    end
    checks++; if (k_done != 3) begin errors++; $display("FAIL rmid_after_done got %0d required 3", k_done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_edge_sizes();
    int n = 0;
    int k_done = -1;
    int k_first = -1;
    int k_last = -1;
    do_reset();
    set_slot(0, 0, 0, 0, 0, 3);
    push_rect(0, 0, 0, 0, 3);
    req = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (plot === 1'b1) n++;
      if (done !== 2'b00) begin k_done = k; req = '0; break; end
    end
    checks++; if (n != 1)      begin errors++; $display("FAIL one_by_one_plots got %0d required 1", n); end
    checks++; if (k_done != 3) begin errors++; $display("FAIL one_by_one_done got %0d required 3", k_done); end
    @(negedge clk);
    n = 0;
    k_done = -1;
    set_slot(0, 100, 50, 15, 15, 4);
    push_rect(100, 50, 15, 15, 4);
    req = 2'b01;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (plot === 1'b1) begin
        if (k_first < 0) k_first = k;
        k_last = k;
        n++;
      end
      if (done !== 2'b00) begin k_done = k; req = '0; break; end
    end
    checks++; if (n != 256) begin errors++; $display("FAIL big_plots got %0d required 256", n); end
    checks++; if (k_last - k_first != 255) begin errors++; $display("FAIL big_span got %0d required 255", k_last - k_first); end
    checks++; if (k_done != 258) begin errors++; $display("FAIL big_done got %0d required 258", k_done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL edge_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_screen_edge();
    int n = 0;
    int k_done = -1;
    int max_x = -1;
    do_reset();
    set_slot(0, 158, 118, 3, 3, 7);
    push_rect(158, 118, 3, 3, 7);
    req = 2'b01;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (plot === 1'b1) begin
        n++;
        if (int'(x) > max_x) max_x = int'(x);
      end
      if (done !== 2'b00) begin k_done = k; req = '0; break; end
    end
`ifdef PLOT_ARBITER_CLIP_EN
    checks++; if (n != 4)       begin errors++; $display("FAIL clip_plots got %0d required 4", n); end
    checks++; if (max_x != 159) begin errors++; $display("FAIL clip_max_x got %0d required 159", max_x); end
`else
    checks++; if (n != 16)      begin errors++; $display("FAIL edge_plots got %0d required 16", n); end
    checks++; if (max_x != 161) begin errors++; $display("FAIL edge_max_x got %0d required 161", max_x); end
`endif
    checks++; if (k_done != 18) begin errors++; $display("FAIL edge_done_cycle got %0d required 18", k_done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL screen_drain got %0d left required 0", exp_q.size()); end
  endtask

  initial begin
    reset      = 1'b1;
    req        = '0;
    req_x      = '0;
    req_y      = '0;
    req_w_m1   = '0;
    req_h_m1   = '0;
    req_colour = '0;
    test_reset();
    test_single();
    test_contention();
    test_midservice();
    test_reset_mid();
    test_edge_sizes();
    test_screen_edge();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
